// File: rtl/tmds_encoder_pipe.sv
// NUM_CH-lane TMDS encoder: input register, q_m stage, disparity/symbol stage.
// Define TMDS_TERC4_EN to add island_in/terc_in and TERC4 data-island symbols.
module tmds_lane (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ce_in,
    input  logic       de_in,
    input  logic [7:0] data_in,
    input  logic [1:0] ctrl_in,
`ifdef TMDS_TERC4_EN
    input  logic       island_in,
    input  logic [3:0] terc_in,
`endif
    output logic [9:0] tmds_out
);
    localparam logic [9:0] TOK_00 = 10'b1101010100;

    function automatic logic [9:0] ctrl_tok(input logic [1:0] c);
        case (c)
            2'b00:   ctrl_tok = TOK_00;
            2'b01:   ctrl_tok = 10'b0010101011;
            2'b10:   ctrl_tok = 10'b0101010100;
            default: ctrl_tok = 10'b1010101011;
        endcase
    endfunction

`ifdef TMDS_TERC4_EN
    function automatic logic [9:0] terc4(input logic [3:0] t);
        case (t)
            4'h0: terc4 = 10'b1010011100;
            4'h1: terc4 = 10'b1001100011;
            4'h2: terc4 = 10'b1011100100;
            4'h3: terc4 = 10'b1011100010;
            4'h4: terc4 = 10'b0101110001;
            4'h5: terc4 = 10'b0100011110;
            4'h6: terc4 = 10'b0110001110;
            4'h7: terc4 = 10'b0100111100;
            4'h8: terc4 = 10'b1011001100;
            4'h9: terc4 = 10'b0100111001;
            4'hA: terc4 = 10'b0110011100;
            4'hB: terc4 = 10'b1011000110;
            4'hC: terc4 = 10'b1010001110;
            4'hD: terc4 = 10'b1001110001;
            4'hE: terc4 = 10'b0101100011;
            default: terc4 = 10'b1011000011;
        endcase
    endfunction

    logic       r_island, r_s1_island;
    logic [3:0] r_terc, r_s1_terc;
`endif

    logic              r_de, r_s1_de;
    logic [7:0]        r_data;
    logic [1:0]        r_ctrl, r_s1_ctrl;
    logic [8:0]        r_qm;
    logic signed [4:0] r_cnt;
    logic [9:0]        r_tmds;

    // Stage 1: transition minimisation on the registered byte
    logic [3:0] w_n1d;
    logic       w_xnor;
    logic [8:0] w_qm;

    always_comb begin
        w_n1d = 4'd0;
        for (int i = 0; i < 8; i++) w_n1d = w_n1d + {3'd0, r_data[i]};
        w_xnor = (w_n1d > 4'd4) || (w_n1d == 4'd4 && !r_data[0]);
        w_qm = '0;
        w_qm[0] = r_data[0];
        for (int i = 1; i < 8; i++)
            w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ r_data[i]) : (w_qm[i-1] ^ r_data[i]);
        w_qm[8] = ~w_xnor;
    end

    // Stage 2: w_diff is n1-n0 of q_m[7:0], always within [-8,+8]
    logic [3:0]        w_n1;
    logic signed [4:0] w_n1s, w_n0s, w_diff, w_cnt_nxt;
    logic [9:0]        w_sym;
    logic              w_q8;

    always_comb begin
        w_n1 = 4'd0;
        for (int i = 0; i < 8; i++) w_n1 = w_n1 + {3'd0, r_qm[i]};
        w_n1s     = signed'({1'b0, w_n1});
        w_n0s     = 5'sd8 - w_n1s;
        w_diff    = w_n1s - w_n0s;
        w_q8      = r_qm[8];
        w_sym     = TOK_00;
        w_cnt_nxt = r_cnt;
        if (r_s1_de) begin
            if (r_cnt == 5'sd0 || w_diff == 5'sd0) begin
                w_sym     = {~w_q8, w_q8, w_q8 ? r_qm[7:0] : ~r_qm[7:0]};
                w_cnt_nxt = w_q8 ? (r_cnt + w_diff) : (r_cnt - w_diff);
            end else if ((r_cnt > 5'sd0 && w_diff > 5'sd0) ||
                         (r_cnt < 5'sd0 && w_diff < 5'sd0)) begin
                w_sym     = {1'b1, w_q8, ~r_qm[7:0]};
                w_cnt_nxt = r_cnt + (w_q8 ? 5'sd2 : 5'sd0) - w_diff;
            end else begin
                w_sym     = {1'b0, w_q8, r_qm[7:0]};
                w_cnt_nxt = r_cnt - (w_q8 ? 5'sd0 : 5'sd2) + w_diff;
            end
        end else begin
            w_cnt_nxt = 5'sd0;
            w_sym     = ctrl_tok(r_s1_ctrl);
`ifdef TMDS_TERC4_EN
            if (r_s1_island) w_sym = terc4(r_s1_terc);
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_de      <= 1'b0;
            r_data    <= '0;
            r_ctrl    <= '0;
            r_s1_de   <= 1'b0;
            r_s1_ctrl <= '0;
            r_qm      <= '0;
            r_cnt     <= '0;
            r_tmds    <= TOK_00;
`ifdef TMDS_TERC4_EN
            r_island    <= 1'b0;
            r_terc      <= '0;
            r_s1_island <= 1'b0;
            r_s1_terc   <= '0;
`endif
        end else if (ce_in) begin
            r_de      <= de_in;
            r_data    <= data_in;
            r_ctrl    <= ctrl_in;
            r_s1_de   <= r_de;
            r_s1_ctrl <= r_ctrl;
            r_qm      <= w_qm;
            r_cnt     <= w_cnt_nxt;
            r_tmds    <= w_sym;
`ifdef TMDS_TERC4_EN
            r_island    <= island_in;
            r_terc      <= terc_in;
            r_s1_island <= r_island;
            r_s1_terc   <= r_terc;
`endif
        end
    end

    assign tmds_out = r_tmds;

    a_cnt_range: assert property (@(posedge clk_in) disable iff (rst_in)
        (r_cnt >= -5'sd10) && (r_cnt <= 5'sd10));
endmodule

module tmds_encoder_pipe #(
    parameter int NUM_CH = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  ce_in,
    input  logic                  de_in,
    input  logic [8*NUM_CH-1:0]   data_in,
    input  logic [2*NUM_CH-1:0]   ctrl_in,
`ifdef TMDS_TERC4_EN
    input  logic                  island_in,
    input  logic [4*NUM_CH-1:0]   terc_in,
`endif
    output logic [10*NUM_CH-1:0]  tmds_out
);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        tmds_lane u_lane (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .ce_in    (ce_in),
            .de_in    (de_in),
            .data_in  (data_in[c*8 +: 8]),
            .ctrl_in  (ctrl_in[c*2 +: 2]),
`ifdef TMDS_TERC4_EN
            .island_in(island_in),
            .terc_in  (terc_in[c*4 +: 4]),
`endif
            .tmds_out (tmds_out[c*10 +: 10])
        );
    end
endmodule
